// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// adder_ctrl_pkg
// Shared types and constants for the nibble-serial add/subtract sequencer.
//   state_e  : controller FSM states (IDLE / RUN / DONE)
//   NIBBLE_W : width of the shared adder slice
//   clog2    : counter-width helper, evaluated at elaboration time
// -----------------------------------------------------------------------------
package adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Smallest r with 2**r >= n.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_four_bit_adder.sv
// -----------------------------------------------------------------------------
// four_bit_adder
// Purely combinational 4-bit ripple slice shared by the serial sequencer.
//   a_i, b_i   : nibble operands
//   cin_i      : carry into the slice
//   sum_o      : nibble sum
//   cout_o     : carry out of the slice
// -----------------------------------------------------------------------------
module four_bit_adder
    import adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                cout_o
);

    logic [NIBBLE_W:0] full;

    always_comb begin
        full   = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};
        sum_o  = full[NIBBLE_W-1:0];
        cout_o = full[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// W-bit add/subtract computed over NIBBLES cycles on one shared 4-bit adder,
// least-significant nibble first, with a registered inter-nibble carry.
//   clk, rst_n            : clock, async active-low reset
//   start_valid/ready     : request handshake; op_a, op_b, op_sub, carry_in
//                           are sampled only on accept
//   res_valid/ready       : response handshake; result, carry_out, overflow
//                           hold until the next accept
//   busy                  : high while an operation is in RUN or DONE
// Subtract is A + ~B + 1: B is inverted at capture and the carry is seeded
// with 1, so carry_out=1 means no borrow.
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    input  logic         carry_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         busy
);

    localparam int CW = clog2(NIBBLES);

    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          carry_q, carry_d;
    nib_vec_t      a_q,     a_d;
    nib_vec_t      b_q,     b_d;     // stored B, already inverted for subtract
    nib_vec_t      res_q,   res_d;
    logic          co_q,    co_d;
    logic          ov_q,    ov_d;

    logic [NIBBLE_W-1:0] add_a, add_b, add_s;
    logic                add_co;
    logic                last_nib;

    // Single shared datapath slice; operands steered by the nibble counter.
    assign add_a    = a_q[cnt_q];
    assign add_b    = b_q[cnt_q];
    assign last_nib = (cnt_q == CW'(NIBBLES - 1));

    four_bit_adder u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (carry_q),
        .sum_o (add_s),
        .cout_o(add_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        co_d    = co_q;
        ov_d    = ov_q;

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub | carry_in;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[cnt_q] = add_s;
                carry_d      = add_co;
                if (last_nib) begin
                    co_d    = add_co;
                    // Signed overflow: operands agree in sign, sum disagrees.
                    ov_d    = (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                              (add_s[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = res_q;
    assign carry_out   = co_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
    localparam longint MOD = 64'd1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a, op_b;
    logic         op_sub, carry_in;
    logic         res_valid, res_ready;
    logic [W-1:0] result;
    logic         carry_out, overflow, busy;

    int nchecks = 0;
    int nerr    = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .carry_in   (carry_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic cin, output logic [W-1:0] r, output logic co,
                         output logic ov);
        longint ua, ub, sa, sb, s, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= MOD / 2) ? ua - MOD : ua;
        sb = (ub >= MOD / 2) ? ub - MOD : ub;
        if (sub) begin
            s  = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            s  = ua + ub + longint'(cin);
            co = (s >= MOD);
            sr = sa + sb + longint'(cin);
        end
        s  = ((s % MOD) + MOD) % MOD;
        r  = W'(s);
        ov = (sr >= MOD / 2) || (sr < -(MOD / 2));
    endtask

    // One full transaction; 'hold' cycles of backpressure in DONE with
    // competing requests offered meanwhile.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input int hold);
        logic [W-1:0] er;
        logic         eco, eov;
        int           k;
        model(a, b, sub, cin, er, eco, eov);
        k = 0;
        while (!start_ready && k < 20) begin @(negedge clk); k++; end
        check({tag, ".ready"}, 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 1'b1; op_a = a; op_b = b; op_sub = sub; carry_in = cin;
        @(posedge clk);
        #1;
        // Inputs scrambled after accept must not matter.
        start_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom);
        op_sub = 1'($urandom); carry_in = 1'($urandom);
        @(negedge clk);
        check({tag, ".clr"}, 32'(result), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        k = 0;
        while (!res_valid && k < 20) begin @(negedge clk); k++; end
        check({tag, ".lat"}, 32'(k), 32'(NIB));
        check({tag, ".res"}, 32'(result), 32'(er));
        check({tag, ".co"}, 32'(carry_out), 32'(eco));
        check({tag, ".ov"}, 32'(overflow), 32'(eov));
        for (int h = 0; h < hold; h++) begin
            start_valid = 1'b1;
            op_a = W'($urandom); op_b = W'($urandom);
            @(posedge clk);
            #1;
            check({tag, ".hold_vld"}, 32'(res_valid), 32'd1);
            check({tag, ".hold_rdy"}, 32'(start_ready), 32'd0);
            check({tag, ".hold_busy"}, 32'(busy), 32'd1);
            check({tag, ".hold_res"}, 32'(result), 32'(er));
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, ".idle_rdy"}, 32'(start_ready), 32'd1);
        check({tag, ".idle_vld"}, 32'(res_valid), 32'd0);
        check({tag, ".idle_res"}, 32'(result), 32'(er));
        check({tag, ".idle_co"}, 32'(carry_out), 32'(eco));
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0; carry_in = 1'b0;
        #12;
        check("rst.ready", 32'(start_ready), 32'd1);
        check("rst.vld", 32'(res_valid), 32'd0);
        check("rst.res", 32'(result), 32'd0);
        check("rst.co", 32'(carry_out), 32'd0);
        check("rst.ov", 32'(overflow), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        run_op("add0c", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op("sub_bor", 16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_op("sub_ok", 16'h0007, 16'h0005, 1'b1, 1'b0, 0);
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 0);
        run_op("bp", 16'hABCD, 16'h1111, 1'b0, 1'b1, 3);

        for (int i = 0; i < 24; i++) begin
            run_op("rnd", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        // Asynchronous reset two cycles into RUN.
        @(negedge clk);
        start_valid = 1'b1; op_a = 16'h1234; op_b = 16'h1111; op_sub = 1'b0; carry_in = 1'b0;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst.ready", 32'(start_ready), 32'd1);
        check("mrst.vld", 32'(res_valid), 32'd0);
        check("mrst.res", 32'(result), 32'd0);
        check("mrst.co", 32'(carry_out), 32'd0);
        check("mrst.ov", 32'(overflow), 32'd0);
        check("mrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post.ready", 32'(start_ready), 32'd1);
        check("post.vld", 32'(res_valid), 32'd0);
        run_op("post", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs a W-bit add or subtract by time-multiplexing one four_bit_adder instance over NIBBLES cycles, least-significant nibble first.
- Holds a registered carry between nibbles.
- Sits between an operand producer (valid/ready request channel) and a result consumer (valid/ready response channel).
- Trades latency for area in the ALSU arithmetic path.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; legal range 2..8.
- W, 4*NIBBLES, derived localparam; operand/result width; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  request valid
- start_ready  out  1  controller can accept a request
- op_a  in  W  operand A, sampled on accept
- op_b  in  W  operand B, sampled on accept
- op_sub  in  1  0 = A+B+carry_in; 1 = A-B; sampled on accept
- carry_in  in  1  add-mode carry seed; ignored when op_sub=1
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- result  out  W  sum/difference
- carry_out  out  1  final carry; in subtract mode 1 = no borrow (A>=B unsigned)
- overflow  out  1  two's-complement signed overflow
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, nibble counter=0, carry register=0, operand registers=0. Output reset values:
  - start_ready=1 (combinational from IDLE)
  - res_valid=0, result=0, carry_out=0, overflow=0, busy=0
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: latch op_a and op_b; latch op_b as ~op_b when op_sub=1.
  - Latch op_sub; carry register <= op_sub ? 1 : carry_in; counter <= 0; go to RUN.
- RUN:
  - Each cycle the adder receives nibble[cnt] of A, nibble[cnt] of stored B, and the carry register.
  - Sum is written to result[4*cnt +: 4]; carry register <= adder carry-out.
  - cnt<NIBBLES-1: cnt++.
  - cnt==NIBBLES-1: carry_out <= adder carry-out; overflow <= (A[W-1]==B'[W-1]) && (Sum[3]!=A[W-1]), where B' is the stored, possibly inverted, B. Go to DONE.
- DONE:
  - res_valid=1; result, carry_out and overflow are stable.
  - On res_ready: go to IDLE.
  - res_ready low: hold indefinitely (backpressure).
- Latency: accept at edge N → res_valid high after edge N+NIBBLES. Earliest next accept is the cycle after the result handshake; no overlap.
- start_valid outside IDLE is ignored, with no side effects. Request inputs are sampled only at accept; changes after accept have no effect.
- In IDLE, result, carry_out and overflow retain the last values; res_valid=0. result is cleared to 0 on accept.
- Reset asserted mid-RUN or mid-DONE: operation is discarded and all outputs take reset values. No result is emitted.
- Widths:
  - All arithmetic is modulo 2^W.
  - The adder is purely combinational; exactly one adder instance is allowed.
  - No W-bit adder may be inferred elsewhere.

Decomposition:
- Package adder_ctrl_pkg:
  - State enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - NIBBLE_W=4.
  - Counter width function clog2(NIBBLES).
- Sub-module: four_bit_adder, instantiated once as the shared datapath slice. All sequencing, muxing and registering lives in nibble_serial_adder_ctrl.

Test Plan (NIBBLES=4):
- Add 0x1234+0x0FFF, carry_in=0 → result=0x2233, carry_out=0, overflow=0; res_valid high exactly 4 cycles after accept. Repeat with 0x0000+0x0000, carry_in=1 → 0x0001.
- Add 0xFFFF+0x0001 → result=0x0000, carry_out=1, overflow=0 (carry ripples through all 4 nibbles).
- Sub 0x0005-0x0007, carry_in=1 (must be ignored) → result=0xFFFE, carry_out=0 (borrow), overflow=0. Sub 0x0007-0x0005 → 0x0002, carry_out=1.
- Add 0x7FFF+0x0001 → result=0x8000, overflow=1, carry_out=0. Sub 0x8000-0x0001 → 0x7FFF, overflow=1.
- Hold res_ready=0 for 3 cycles in DONE while pulsing start_valid with new operands → result stable, start_ready=0, busy=1, new request not taken. Raise res_ready → IDLE next cycle, start_ready=1.
- Drop rst_n asynchronously 2 cycles into RUN → all outputs at reset values immediately. After release: start_ready=1, res_valid=0, and the next request 0x0001+0x0001 → 0x0002.
